// File: rtl/uart_tx.sv
// UART transmitter: a small byte FIFO feeding an LSB-first serialiser with
// optional odd/even parity and one or two stop bits, timed by a baud divider.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  din,
  input  logic                        din_valid,
  output logic                        din_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    sr_q, sr_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [7:0]    head;
  logic          push;
  logic          pop;
  logic          bit_end;

  assign din_ready  = (count_q != FULL_CNT);
  assign push       = din_valid && din_ready;
  assign head       = fifo_mem[rd_ptr_q];
  assign bit_end    = (baud_q == BAUD_LAST);
  assign tx         = tx_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);

  // Storage is not reset; emptiness is tracked solely by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= din;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    par_d     = par_q;
    tx_d      = tx_q;
    pop       = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_d      = sr_q[0];
          sr_d      = {1'b0, sr_q[7:1]};
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q != 3'd7) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = sr_q[0];
            sr_d      = {1'b0, sr_q[7:1]};
          end else if (PARITY != 0) begin
            tx_d    = par_q;
            state_d = S_PARITY;
          end else begin
            tx_d      = 1'b1;
            bit_cnt_d = '0;
            state_d   = S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          tx_d      = 1'b1;
          bit_cnt_d = '0;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        // bit_cnt counts stop bits here so two stop bits need no wider divider
        if (bit_end) begin
          if (bit_cnt_q != STOP_LAST) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else if (count_q != '0) begin
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      sr_d      = head;
      par_d     = (PARITY == 1) ? ~(^head) : (^head);
      bit_cnt_d = '0;
      baud_d    = '0;
      tx_d      = 1'b0;
      state_d   = S_START;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four instances (no parity, even, odd, two
// stop bits) driven with directed and random bytes, decoded by a line monitor.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int NI    = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din        [NI];
  logic       din_valid  [NI];
  logic       din_ready  [NI];
  logic       tx         [NI];
  logic       busy       [NI];
  logic [2:0] fifo_count [NI];

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected bytes in acceptance order, plus what the line monitor observed
  logic [7:0]  exp_q    [NI][$];
  logic [11:0] frames_q [NI][$];
  int          starts_q [NI][$];
  int          runs_q   [NI][$];

  bit          in_frame    [NI];
  int          fcyc        [NI];
  int          hi_run      [NI];
  logic [11:0] frm         [NI];
  bit          unstable    [NI];
  int          frames_done [NI];
  int          cyc_t = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc_t <= cyc_t + 1;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .PARITY      ((g == 1) ? 2 : ((g == 2) ? 1 : 0)),
        .STOP_BITS   ((g == 3) ? 2 : 1)
      ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din[g]),
        .din_valid (din_valid[g]),
        .din_ready (din_ready[g]),
        .tx        (tx[g]),
        .busy      (busy[g]),
        .fifo_count(fifo_count[g])
      );
    end
  endgenerate

  // Configuration of each instance as seen by the reference model
  function automatic int par_of(int i);
    return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
  endfunction

  function automatic int stop_of(int i);
    return (i == 3) ? 2 : 1;
  endfunction

  function automatic int frame_len(int i);
    return (10 + ((par_of(i) != 0) ? 1 : 0) + stop_of(i) - 1) * CPB;
  endfunction

  // Expected line bits of one frame, one entry per bit period, idle-high padding
  function automatic logic [11:0] exp_frame(int i, logic [7:0] b);
    logic [11:0] v;
    logic        odd_ones;
    v        = '1;
    v[0]     = 1'b0;
    v[8:1]   = b;
    odd_ones = ($countones(b) % 2) == 1;
    if (par_of(i) == 2) v[9] = odd_ones;
    if (par_of(i) == 1) v[9] = !odd_ones;
    return v;
  endfunction

  task automatic checkOutput(string tag, int inst, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s[%0d]: observed %0h expected %0h", tag, inst, obs, exp);
    end
  endtask

  // Line monitor: frame starts on the first low sample, each bit is the value
  // at the first cycle of its period and must hold for the whole period.
  always @(negedge clk) begin
    int         k;
    logic [7:0] eb;
    for (int i = 0; i < NI; i++) begin
      if (rst_n !== 1'b1) begin
        in_frame[i] = 1'b0;
        hi_run[i]   = 0;
      end else begin
        if (!in_frame[i] && tx[i] === 1'b0) begin
          in_frame[i] = 1'b1;
          fcyc[i]     = 0;
          unstable[i] = 1'b0;
          frm[i]      = '1;
          starts_q[i].push_back(cyc_t);
          runs_q[i].push_back(hi_run[i]);
        end
        hi_run[i] = (tx[i] === 1'b1) ? hi_run[i] + 1 : 0;
        if (in_frame[i]) begin
          k = fcyc[i] / CPB;
          if (fcyc[i] % CPB == 0) frm[i][k] = tx[i];
          else if (tx[i] !== frm[i][k]) unstable[i] = 1'b1;
          fcyc[i]++;
          if (fcyc[i] == frame_len(i)) begin
            if (exp_q[i].size() > 0) eb = exp_q[i].pop_front();
            else eb = 8'hxx;
            frames_q[i].push_back(frm[i]);
            checkOutput("frame_bits", i, 32'(frm[i]), 32'(exp_frame(i, eb)));
            checkOutput("frame_stable", i, 32'(unstable[i]), 32'd0);
            frames_done[i]++;
            in_frame[i] = 1'b0;
          end
        end
      end
    end
  end

  // One handshake: present the byte, wait for din_ready, let one edge accept it
  task automatic applyStimulus(input int i, input logic [7:0] b,
                               output int waited, output logic [2:0] cnt_at_ready);
    waited = 0;
    @(negedge clk);
    din[i]       = b;
    din_valid[i] = 1'b1;
    while (din_ready[i] !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    cnt_at_ready = fifo_count[i];
    if (waited >= 300) checkOutput("ready_timeout", i, 32'(din_ready[i]), 32'd1);
    @(posedge clk);
    exp_q[i].push_back(b);
    #1;
    din_valid[i] = 1'b0;
  endtask

  task automatic waitDrain(input int i);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while ((busy[i] !== 1'b0 || in_frame[i]) && w < 2000);
    checkOutput("drain", i, 32'(busy[i]), 32'd0);
    checkOutput("exp_left", i, exp_q[i].size(), 32'd0);
  endtask

  task automatic checkContiguous(input int i, input int n);
    checkOutput("frame_count", i, starts_q[i].size(), n);
    for (int j = 1; j < starts_q[i].size(); j++)
      checkOutput("frame_gap", i, starts_q[i][j] - starts_q[i][j-1], frame_len(i));
  endtask

  task automatic clearLogs(input int i);
    starts_q[i].delete();
    runs_q[i].delete();
    frames_q[i].delete();
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          w;
    int          fd0;
    int          bad;
    logic [2:0]  c;
    logic [11:0] ef;

    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      din[i]         = 8'h00;
      din_valid[i]   = 1'b0;
      frames_done[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checkOutput("rst_tx", i, 32'(tx[i]), 32'd1);
      checkOutput("rst_ready", i, 32'(din_ready[i]), 32'd1);
      checkOutput("rst_busy", i, 32'(busy[i]), 32'd0);
      checkOutput("rst_count", i, 32'(fifo_count[i]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5, then cycle-exact line and busy timing
    $display("[TB] single byte 0xA5");
    ef = exp_frame(0, 8'hA5);
    applyStimulus(0, 8'hA5, w, c);
    @(negedge clk);
    checkOutput("s1_count", 0, 32'(fifo_count[0]), 32'd1);
    checkOutput("s1_busy", 0, 32'(busy[0]), 32'd1);
    checkOutput("s1_tx_idle", 0, 32'(tx[0]), 32'd1);
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clk);
      checkOutput("s1_tx", 0, 32'(tx[0]), 32'(ef[k / CPB]));
      if (k == 0) checkOutput("s1_popped", 0, 32'(fifo_count[0]), 32'd0);
    end
    checkOutput("s1_busy_stop", 0, 32'(busy[0]), 32'd1);
    @(negedge clk);
    checkOutput("s1_busy_end", 0, 32'(busy[0]), 32'd0);
    checkOutput("s1_tx_end", 0, 32'(tx[0]), 32'd1);

    // Six bytes into a four-deep FIFO: stall, no loss, back-to-back frames
    $display("[TB] six-byte burst");
    clearLogs(0);
    for (int b = 1; b <= 6; b++) begin
      if (b == 6) begin
        @(negedge clk);
        checkOutput("s2_full_ready", 0, 32'(din_ready[0]), 32'd0);
        checkOutput("s2_full_count", 0, 32'(fifo_count[0]), 32'd4);
      end
      applyStimulus(0, 8'(b), w, c);
      if (b == 6) begin
        checkOutput("s2_stalled", 0, 32'(w > 0), 32'd1);
        checkOutput("s2_count_at_pop", 0, 32'(c), 32'd3);
      end
    end
    waitDrain(0);
    checkContiguous(0, 6);

    // Full FIFO with 0x55 held while a pop happens: pop only, push next cycle
    $display("[TB] full FIFO with simultaneous pop");
    clearLogs(0);
    for (int b = 0; b < 5; b++) applyStimulus(0, 8'($urandom), w, c);
    applyStimulus(0, 8'h55, w, c);
    checkOutput("s5_stalled", 0, 32'(w > 0), 32'd1);
    checkOutput("s5_count_at_pop", 0, 32'(c), 32'd3);
    @(negedge clk);
    checkOutput("s5_count_after", 0, 32'(fifo_count[0]), 32'd4);
    checkOutput("s5_ready_after", 0, 32'(din_ready[0]), 32'd0);
    waitDrain(0);
    checkContiguous(0, 6);

    // Parity instances: 0x07 first, then random bytes
    for (int i = 1; i <= 2; i++) begin
      $display("[TB] parity instance %0d", i);
      clearLogs(i);
      applyStimulus(i, 8'h07, w, c);
      for (int b = 0; b < 3; b++) applyStimulus(i, 8'($urandom), w, c);
      waitDrain(i);
      checkContiguous(i, 4);
    end
    checkOutput("even_par_07", 1, 32'(frames_q[1][0][9]), 32'd1);
    checkOutput("odd_par_07", 2, 32'(frames_q[2][0][9]), 32'd0);

    // Two stop bits: 0x00 then 0xFF leaves exactly 2*CPB high cycles between
    $display("[TB] two stop bits");
    clearLogs(3);
    applyStimulus(3, 8'h00, w, c);
    applyStimulus(3, 8'hFF, w, c);
    for (int b = 0; b < 2; b++) applyStimulus(3, 8'($urandom), w, c);
    waitDrain(3);
    checkContiguous(3, 4);
    checkOutput("stop2_high_run", 3, runs_q[3][1], 2 * CPB);

    // Reset mid-frame with two bytes queued
    $display("[TB] reset during data");
    clearLogs(0);
    for (int b = 0; b < 3; b++) applyStimulus(0, 8'($urandom), w, c);
    w = 0;
    while (tx[0] !== 1'b0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    checkOutput("s6_started", 0, 32'(tx[0]), 32'd0);
    repeat (2 * CPB + 2) @(negedge clk);
    checkOutput("s6_queued", 0, 32'(fifo_count[0]), 32'd2);
    fd0 = frames_done[0];
    #2 rst_n = 1'b0;
    #1;
    checkOutput("s6_tx", 0, 32'(tx[0]), 32'd1);
    checkOutput("s6_count", 0, 32'(fifo_count[0]), 32'd0);
    checkOutput("s6_busy", 0, 32'(busy[0]), 32'd0);
    exp_q[0].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 15 * CPB; k++) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    checkOutput("s6_quiet", 0, bad, 32'd0);
    checkOutput("s6_no_frames", 0, frames_done[0] - fd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: accepts bytes over a valid/ready handshake, buffers them in a small FIFO, and serialises them on `tx` as asynchronous frames. Frames are LSB-first with a start bit, optional parity, and 1 or 2 stop bits. Bit timing comes from an internal divider on the system clock. It is the transmit-side counterpart of the UART receive path and uses the same line format, 8 data bits at 115200 baud from 50 MHz by default.

## Interface
- `CLKS_PER_BIT`, 434: `clk` cycles per bit period (50 MHz / 115200, rounded); legal range ≥ 2.
- `FIFO_DEPTH`, 4: transmit FIFO entries; power of two, ≥ 2.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  8  byte to transmit.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  FIFO can accept a byte; equals (count < FIFO_DEPTH), registered-state only, with no combinational path from `din_valid`.
- `tx`  out  1  serial line; registered output; idles high.
- `busy`  out  1  high when a frame is in progress or the FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes waiting in the FIFO, excluding the byte being sent.

## Operation
- Push: when `din_valid && din_ready` at an edge, `din` is written at the tail and `fifo_count` increments.
  - When full, `din_ready`=0 and the byte is not accepted, even if a pop occurs in the same cycle.
- Push and pop in the same cycle: `fifo_count` is unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx`=1.
  - If the FIFO is non-empty at an edge: pop the head into shift register SR, clear bit counter and baud counter, set `tx`<=0, go to START.
- Baud counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state. Each bit lasts exactly CLKS_PER_BIT cycles, and the bit ends when the counter equals CLKS_PER_BIT-1.
- START, at bit end: `tx`<=SR[0], SR shifts right, go to DATA.
- DATA:
  - At bit end with bit counter < 7: increment the bit counter and output the next bit.
  - At bit end with bit counter = 7: go to PARITY if PARITY≠0, else to STOP; in either case `tx`<=1 for STOP, or `tx`<=parity bit for PARITY.
- Parity bit:
  - Even: the XOR of the 8 data bits.
  - Odd: the inverse of that XOR.
  - Computed from the popped byte, held in a register.
- PARITY, at bit end: `tx`<=1, go to STOP.
- STOP:
  - Lasts STOP_BITS × CLKS_PER_BIT cycles.
  - At its end, if the FIFO is non-empty: pop, `tx`<=0, go to START (back-to-back frames with no idle gap). Otherwise go to IDLE.
- Frame length is (10 + (PARITY≠0) + (STOP_BITS-1)) × CLKS_PER_BIT cycles.
- `busy` = (state ≠ IDLE) || (`fifo_count` ≠ 0).

## Timing
- Reset values: `tx`=1, `din_ready`=1, `busy`=0, `fifo_count`=0, state IDLE, FIFO empty.
  - Reset asserted mid-frame aborts the frame: `tx` returns to 1 asynchronously and FIFO contents are discarded.
  - Operation starts on the first clock edge after `rst_n` deasserts.
- Latency, byte accepted at edge k while IDLE with the FIFO empty:
  - The FIFO becomes non-empty after edge k.
  - `tx` falls after edge k+1.
  - The start bit is low for CLKS_PER_BIT cycles.
- `fifo_count` updates on the edge after a push or pop. `din_ready` deasserts on the edge after the push that fills the FIFO, and reasserts on the edge after the next pop.
- `tx` is driven from a flop only and never glitches.
- The baud counter width is $clog2(CLKS_PER_BIT). It resets to 0 at every bit boundary, so there is no cumulative drift.

## Test plan
Use CLKS_PER_BIT=4 for all scenarios unless noted.

- Single byte 0xA5, PARITY=0, STOP_BITS=1 -> starting 1 cycle after accept:
  - `tx` sequence, one value per 4 cycles: 0,1,0,1,0,0,1,0,1,1.
  - `busy` falls 40 cycles after the fall of `tx`.
- Push 6 bytes 0x01..0x06 continuously with FIFO_DEPTH=4 ->
  - `din_ready`=0 once 4 are queued; extra pushes are stalled and none are lost.
  - Six contiguous 40-cycle frames with no idle gap, in order.
- PARITY=2, byte 0x07 -> parity bit 1. PARITY=1, byte 0x07 -> parity bit 0. Frame is 44 cycles.
- STOP_BITS=2, bytes 0x00 and 0xFF back-to-back -> `tx` is high for exactly 8 cycles between the last data bit of frame 1 and the start bit of frame 2.
- Hold `din_valid` high with `din`=0x55 while the FIFO is full and a pop occurs in the same cycle -> the push is not accepted that cycle and `fifo_count` decrements by 1.
- Assert `rst_n`=0 during the DATA state with 2 bytes queued -> `tx`=1 immediately and `fifo_count`=0. After release, with no new push, `tx` stays 1 and `busy`=0.
